dht_read_scheduler: RTL and testbench
=====================================

// Module: dht_read_scheduler
// PURPOSE
//  Sequences periodic DHT11 reads through the one-wire driver (start/busy/done handshake) and checks the checksum.
//  Latches validated humidity/temperature bytes into stable registers that feed the FND formatting path.
//  Retries failed reads and flags persistent sensor failure. Display data only changes on a clean read.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency; 1 ms = CLK_HZ/1000 cycles (integer)
//  PERIOD_MS   2000         gap from end of a read cycle (success or give-up) to next start; also power-up delay
//  TIMEOUT_MS  10           max wait for i_done after o_start
//  RETRY_MS    1100         gap between a failed attempt and its retry
//  MAX_RETRY   3            retries after first failure before giving up (attempts = MAX_RETRY+1)
// PORTS
//  clk              input   1   system clock, rising edge
//  rst              input   1   asynchronous, active-low reset
//  i_enable         input   1   level; 1 = run periodic reads
//  o_start          output  1   one-cycle pulse: driver begins a transaction
//  i_busy           input   1   driver transaction in progress (status only)
//  i_done           input   1   one-cycle pulse: driver finished, i_data valid this cycle
//  i_data           input   40  {humi_int, humi_dec, temp_int, temp_dec, parity}, MSB first
//  o_humi_integral  output  8   last validated humidity integer byte
//  o_humi_decimal   output  8   last validated humidity decimal byte
//  o_temp_integral  output  8   last validated temperature integer byte
//  o_temp_decimal   output  8   last validated temperature decimal byte
//  o_update         output  1   one-cycle pulse when the four data outputs change
//  o_valid          output  1   sticky: at least one read validated since reset
//  o_err            output  1   level: last read cycle exhausted all retries
//  o_fail_cnt       output  8   total failed attempts, saturates at 255
// BEHAVIOUR
//  Reset: all outputs 0, state IDLE, all counters 0. Asserts immediately; release is sampled on clk.
//  All waits are exact: the ms timer restarts on every state entry. N ms = N*CLK_HZ/1000 cycles.
//  FSM:
//   IDLE:     stay while i_enable=0. Go to WAIT_PER when i_enable=1.
//   WAIT_PER: after PERIOD_MS go to START. If i_enable=0, go to IDLE.
//   START:    o_start=1 for exactly this cycle, then WAIT_DONE, with attempt counter unchanged.
//   WAIT_DONE: on i_done, capture i_data into a shadow register and go to CHECK.
//              If TIMEOUT_MS elapses without i_done, the attempt fails; go to FAIL.
//              If i_done and the timeout land on the same cycle, i_done wins.
//   CHECK (1 cycle): ok = (hi+hd+ti+td) mod 256 == parity (8-bit wrapping sum).
//     ok: load the four output regs, set o_valid, clear o_err, clear retry count; o_update=1 next cycle; go to WAIT_PER.
//     not ok: go to FAIL.
//   FAIL (1 cycle): o_fail_cnt+1 (saturating at 255).
//     If retry count < MAX_RETRY: retry count+1, go to WAIT_RTY.
//     Otherwise: set o_err, clear retry count, go to WAIT_PER; data outputs hold.
//   WAIT_RTY: after RETRY_MS go to START. If i_enable=0, go to IDLE.
//  i_enable=0 during START/WAIT_DONE/CHECK/FAIL does not abort; the transaction completes.
//  At the next WAIT_PER or WAIT_RTY entry the FSM goes to IDLE and the retry count clears.
//  i_done outside WAIT_DONE is ignored. i_busy is never required for progress.
//  Latency: i_done edge -> output regs updated 2 clk later; o_update high on that same cycle.
//  Data outputs never change except via a CHECK pass (no partial or corrupt values shown).
// TESTING (CLK_HZ=1000 so 1 ms = 1 cycle; PERIOD_MS=4, TIMEOUT_MS=3, RETRY_MS=2, MAX_RETRY=2)
//  - rst low with i_enable=1, then release -> o_start first pulses 4 cycles after WAIT_PER entry;
//    all outputs 0 before that.
//  - done with data 0x32_00_19_00_4B -> humi=0x32/0x00, temp=0x19/0x00;
//    o_update pulses 2 cycles after done; o_valid=1, o_err=0.
//  - parity 0x4C x3 attempts -> 3 o_start pulses spaced by retry gap; o_err=1; o_fail_cnt=3;
//    prior data held; next good read clears o_err.
//  - no i_done after o_start -> fail after 3 cycles; i_done on the timeout cycle -> accepted as done.
//  - sum wrap: bytes 0xFF,0x01,0x80,0x80 with parity 0x00 -> accepted.
//  - i_enable drops in WAIT_DONE -> done still processed and data latched, then IDLE with no further o_start;
//    rst low mid-WAIT_DONE clears all outputs at once.

Source files
------------

// File: rtl/dht_read_scheduler.sv
// dht_read_scheduler: periodic DHT11 read sequencing with checksum validation, retries and failure flagging
module dht_read_scheduler #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int PERIOD_MS  = 2000,
  parameter int TIMEOUT_MS = 10,
  parameter int RETRY_MS   = 1100,
  parameter int MAX_RETRY  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_enable,
  output logic        o_start,
  input  logic        i_busy,
  input  logic        i_done,
  input  logic [39:0] i_data,
  output logic [7:0]  o_humi_integral,
  output logic [7:0]  o_humi_decimal,
  output logic [7:0]  o_temp_integral,
  output logic [7:0]  o_temp_decimal,
  output logic        o_update,
  output logic        o_valid,
  output logic        o_err,
  output logic [7:0]  o_fail_cnt
);
  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] WAIT_PER  = 3'd1;
  localparam logic [2:0] START     = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] CHECK     = 3'd4;
  localparam logic [2:0] FAIL      = 3'd5;
  localparam logic [2:0] WAIT_RTY  = 3'd6;
  localparam logic [31:0] MS_C  = 32'(CLK_HZ / 1000);
  localparam logic [31:0] PER_C = MS_C * 32'(PERIOD_MS);
  localparam logic [31:0] TO_C  = MS_C * 32'(TIMEOUT_MS);
  localparam logic [31:0] RTY_C = MS_C * 32'(RETRY_MS);
  logic [2:0]  state_q, state_d;
  logic [31:0] tmr_q, tmr_d;
  logic [7:0]  retry_q, retry_d, fcnt_q, fcnt_d;
  logic [39:0] sh_q, sh_d;
  logic [31:0] data_q, data_d;
  logic        upd_q, upd_d, valid_q, valid_d, err_q, err_d;
  logic [7:0]  sum;
  logic        unused_ok;
  // busy is informational only; progress relies on done or timeout
  assign unused_ok = i_busy;
  assign sum = sh_q[39:32] + sh_q[31:24] + sh_q[23:16] + sh_q[15:8];
  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    fcnt_d  = fcnt_q;
    sh_d    = sh_q;
    data_d  = data_q;
    upd_d   = 1'b0;
    valid_d = valid_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        retry_d = '0;
        state_d = i_enable ? WAIT_PER : IDLE;
      end
      WAIT_PER: begin
        retry_d = i_enable ? retry_q : '0;
        state_d = !i_enable ? IDLE : (tmr_q == PER_C - 32'd1) ? START : WAIT_PER;
      end
      START: state_d = WAIT_DONE;
      WAIT_DONE: begin
        sh_d    = i_done ? i_data : sh_q;
        state_d = i_done ? CHECK : (tmr_q == TO_C - 32'd1) ? FAIL : WAIT_DONE;
      end
      CHECK: begin
        if (sum == sh_q[7:0]) begin
          data_d  = sh_q[39:8];
          upd_d   = 1'b1;
          valid_d = 1'b1;
          err_d   = 1'b0;
          retry_d = '0;
          state_d = WAIT_PER;
        end else state_d = FAIL;
      end
      FAIL: begin
        fcnt_d = fcnt_q + {7'd0, fcnt_q != 8'hFF};
        if (retry_q < 8'(MAX_RETRY)) begin
          retry_d = retry_q + 8'd1;
          state_d = WAIT_RTY;
        end else begin
          err_d   = 1'b1;
          retry_d = '0;
          state_d = WAIT_PER;
        end
      end
      WAIT_RTY: begin
        retry_d = i_enable ? retry_q : '0;
        state_d = !i_enable ? IDLE : (tmr_q == RTY_C - 32'd1) ? START : WAIT_RTY;
      end
      default: state_d = IDLE;
    endcase
    tmr_d = (state_d == state_q) ? tmr_q + 32'd1 : '0;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      retry_q <= '0;
      fcnt_q  <= '0;
      sh_q    <= '0;
      data_q  <= '0;
      upd_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      retry_q <= retry_d;
      fcnt_q  <= fcnt_d;
      sh_q    <= sh_d;
      data_q  <= data_d;
      upd_q   <= upd_d;
      valid_q <= valid_d;
      err_q   <= err_d;
    end
  end
  assign o_start         = state_q == START;
  assign o_humi_integral = data_q[31:24];
  assign o_humi_decimal  = data_q[23:16];
  assign o_temp_integral = data_q[15:8];
  assign o_temp_decimal  = data_q[7:0];
  assign o_update        = upd_q;
  assign o_valid         = valid_q;
  assign o_err           = err_q;
  assign o_fail_cnt      = fcnt_q;
endmodule

// File: tb/tb_dht_read_scheduler.sv
// tb_dht_read_scheduler: directed checks of read scheduling, checksum, retries, timeout and reset
module tb_dht_read_scheduler;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        busy = 1'b0;
  logic        done = 1'b0;
  logic [39:0] data = '0;
  logic        start, upd, valid, err;
  logic [7:0]  hi, hd, ti, td, fcnt;
  int          n_chk = 0;
  int          n_err = 0;
  int          n;
  logic        found;

  dht_read_scheduler #(
    .CLK_HZ(1000), .PERIOD_MS(4), .TIMEOUT_MS(3), .RETRY_MS(2), .MAX_RETRY(2)
  ) dut (
    .clk(clk), .rst(rst), .i_enable(en), .o_start(start), .i_busy(busy),
    .i_done(done), .i_data(data), .o_humi_integral(hi), .o_humi_decimal(hd),
    .o_temp_integral(ti), .o_temp_decimal(td), .o_update(upd), .o_valid(valid),
    .o_err(err), .o_fail_cnt(fcnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int max, output int cnt, output logic hit);
    cnt = 0;
    hit = 1'b0;
    while (!hit && cnt < max) begin
      tick();
      cnt++;
      hit = start;
    end
  endtask

  task automatic do_read(input logic [39:0] d, input int dly);
    tick();
    repeat (dly) tick();
    done = 1'b1;
    data = d;
    tick();
    done = 1'b0;
    data = '0;
  endtask

  initial begin
    en = 1'b1;
    #2 rst = 1'b0;
    repeat (3) tick();
    check("rst_data", {hi, hd, ti, td}, 32'h0);
    check("rst_flags", {start, upd, valid, err}, 4'h0);
    check("rst_fcnt", fcnt, 8'h0);
    rst = 1'b1;
    wait_start(20, n, found);
    check("first_start_gap", n, 5);
    check("pre_data", {hi, hd, ti, td, valid}, 33'h0);
    do_read(40'h32_00_19_00_4B, 0);
    check("upd_early", upd, 1'b0);
    tick();
    check("upd_pulse", upd, 1'b1);
    check("good_data", {hi, hd, ti, td}, 32'h32_00_19_00);
    check("good_flags", {valid, err}, 2'b10);
    wait_start(20, n, found);
    check("period_gap", n, 4);
    for (int i = 0; i < 3; i++) begin
      do_read(40'h40_01_20_02_4C, 0);
      if (i < 2) begin
        wait_start(20, n, found);
        check("retry_gap", n, 4);
        check("retry_fcnt", fcnt, 8'(i + 1));
        check("retry_err", err, 1'b0);
      end
    end
    tick();
    tick();
    check("giveup_err", err, 1'b1);
    check("giveup_fcnt", fcnt, 8'd3);
    check("giveup_hold", {hi, hd, ti, td, valid}, {32'h32_00_19_00, 1'b1});
    wait_start(20, n, found);
    check("post_giveup_gap", n, 4);
    do_read(40'h41_05_17_03_60, 0);
    tick();
    check("recover_upd", upd, 1'b1);
    check("recover_data", {hi, hd, ti, td}, 32'h41_05_17_03);
    check("recover_err", err, 1'b0);
    wait_start(20, n, found);
    check("gap_before_to", n, 4);
    repeat (4) tick();
    check("to_fcnt_before", fcnt, 8'd3);
    tick();
    check("to_fcnt_after", fcnt, 8'd4);
    wait_start(20, n, found);
    check("to_retry_gap", n, 2);
    do_read(40'h10_20_30_40_A0, 2);
    tick();
    check("late_done_upd", upd, 1'b1);
    check("late_done_data", {hi, hd, ti, td}, 32'h10_20_30_40);
    check("late_done_fcnt", fcnt, 8'd4);
    wait_start(20, n, found);
    check("gap_wrap", n, 4);
    do_read(40'hFF_01_80_80_00, 0);
    tick();
    check("wrap_upd", upd, 1'b1);
    check("wrap_data", {hi, hd, ti, td}, 32'hFF_01_80_80);
    wait_start(20, n, found);
    check("gap_dis", n, 4);
    tick();
    en = 1'b0;
    done = 1'b1;
    data = 40'h22_00_11_00_33;
    tick();
    done = 1'b0;
    data = '0;
    tick();
    check("dis_upd", upd, 1'b1);
    check("dis_data", {hi, hd, ti, td}, 32'h22_00_11_00);
    wait_start(20, n, found);
    check("dis_no_start", found, 1'b0);
    en = 1'b1;
    wait_start(20, n, found);
    check("reen_gap", n, 5);
    tick();
    #2 rst = 1'b0;
    #1;
    check("arst_data", {hi, hd, ti, td}, 32'h0);
    check("arst_flags", {start, upd, valid, err}, 4'h0);
    check("arst_fcnt", fcnt, 8'h0);
    tick();
    rst = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
